// File: rtl/fir_filter.sv
// 8-tap symmetric low-pass FIR (2,4,8,18,18,8,4,2)/64 on a signed sample stream, one sample per clock.
// Latency: data_out reflects data_in two edges after it is presented; no backpressure, every clock is a sample.
module fir_filter #(
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] data_in,
    output logic signed [N-1:0] data_out
);

    localparam int ACC_W = N + 8;

    logic signed [N-1:0]     x   [8];
    logic signed [ACC_W-1:0] pre [4];
    logic signed [ACC_W-1:0] acc;

    // Symmetric taps share a coefficient, so pre-add mirrored pairs and
    // scale each pair by shifts (18 = 16 + 2).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pre[k] = ACC_W'(x[k]) + ACC_W'(x[7-k]);
        end
        acc = (pre[0] <<< 1) + (pre[1] <<< 2) + (pre[2] <<< 3)
            + (pre[3] <<< 4) + (pre[3] <<< 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                x[k] <= '0;
            end
            data_out <= '0;
        end else begin
            x[0] <= data_in;
            for (int k = 1; k < 8; k++) begin
                x[k] <= x[k-1];
            end
            // Coefficients sum to 64, so the floor-scaled result always fits N bits.
            data_out <= N'(acc >>> 6);
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: a software model of the tap formula pushes expected outputs,
// which are popped and compared one edge later; literal tables cover impulse, step and truncation.
module tb_fir_filter;

    logic               clk;
    logic               reset;
    logic signed [15:0] data_in;
    logic signed [15:0] data_out;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] sb_q [$];
    int mx [8];
    int h  [8] = '{2, 4, 8, 18, 18, 8, 4, 2};

    int imp_tab  [10] = '{0, 2, 4, 8, 18, 18, 8, 4, 2, 0};
    int neg_tab  [10] = '{0, -1, -1, -1, -1, -1, -1, -1, -1, 0};
    int step_tab [9]  = '{0, 31, 93, 218, 500, 781, 906, 968, 1000};
    int sine_tab [32];

    fir_filter #(.N(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [15:0] got, input logic signed [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample, push the model's prediction, then pop and compare after the edge.
    task automatic step(input int s, input logic rst);
        int acc;
        logic signed [15:0] exp;
        @(negedge clk);
        data_in = 16'(s);
        reset   = rst;
        if (!rst) begin
            exp = '0;
            for (int k = 0; k < 8; k++) mx[k] = 0;
        end else begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc += h[k] * mx[k];
            exp = 16'(acc >>> 6);
            for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = $signed(16'(s));
        end
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            check("model", data_out, sb_q.pop_front());
        end
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 16'sd1234;
        for (int i = 0; i < 32; i++) begin
            sine_tab[i] = $rtoi(16000.0 * $sin(2.0 * 3.14159265358979 * i / 32.0));
        end

        // Reset held two edges with nonzero input, then first released edge.
        step(1234, 1'b0);
        check("rst0", data_out, 16'sd0);
        step(1234, 1'b0);
        check("rst1", data_out, 16'sd0);
        step(0, 1'b1);
        check("rst_rel", data_out, 16'sd0);
        for (int i = 0; i < 8; i++) step(0, 1'b1);

        // Impulse of 64 reproduces the coefficients.
        step(64, 1'b1);
        check("imp", data_out, 16'(imp_tab[0]));
        for (int i = 1; i < 10; i++) begin
            step(0, 1'b1);
            check("imp", data_out, 16'(imp_tab[i]));
        end

        // -1 impulse: floor of every negative partial is -1.
        step(-1, 1'b1);
        check("trunc", data_out, 16'(neg_tab[0]));
        for (int i = 1; i < 10; i++) begin
            step(0, 1'b1);
            check("trunc", data_out, 16'(neg_tab[i]));
        end

        // Step response to 1000 from zero history.
        for (int i = 0; i < 9; i++) begin
            step(1000, 1'b1);
            check("step", data_out, 16'(step_tab[i]));
        end
        for (int i = 0; i < 4; i++) step(1000, 1'b1);
        check("dc1000", data_out, 16'sd1000);

        // Mid-stream reset discards history; response retraces from zero.
        step(1000, 1'b0);
        check("mid_rst", data_out, 16'sd0);
        for (int i = 0; i < 9; i++) begin
            step(1000, 1'b1);
            check("restep", data_out, 16'(step_tab[i]));
        end

        // Full-scale DC in both directions.
        for (int i = 0; i < 10; i++) step(32767, 1'b1);
        check("dc_max", data_out, 16'sd32767);
        for (int i = 0; i < 10; i++) step(-32768, 1'b1);
        check("dc_min", data_out, -16'sd32768);
        for (int i = 0; i < 10; i++) step(32767, 1'b1);
        check("dc_swing", data_out, 16'sd32767);

        // Repeated sine table, model-checked every sample including wrap.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 32; i++) step(sine_tab[i], 1'b1);
        end

        // Random stream.
        for (int i = 0; i < 200; i++) step($signed(16'($urandom)), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
